// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the single-port data memory.
// Optional macro MEM_ARB_RANGE_CHECK_EN blocks and flags accesses at addresses >= MEM_WORDS.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

`ifdef MEM_ARB_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              cur_q, cur_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              grant_en;
    logic              grant_sel;
    logic              oor;
    logic [DATA_W-1:0] rd_val;

    // The latched address stays stable through RESP, so one compare serves both
    // the ACCESS strobe gating and the err flag presented with ack.
    assign oor = RANGE_CHECK && (addr_q >= ADDR_W'(MEM_WORDS));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves a
        // value unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        cur_d     = cur_q;
        last_d    = last_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        grant_en  = 1'b0;
        grant_sel = 1'b0;
        rd_val    = oor ? '0 : mem_dout;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_en  = 1'b1;
                    grant_sel = (m0_req && m1_req) ? ~last_q : m1_req;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!we_q) begin
                    if (cur_q) rdata1_d = rd_val;
                    else       rdata0_d = rd_val;
                end
            end
            RESP: begin
                // The requester being acked is ignored here; only the other may chain.
                if (cur_q ? m0_req : m1_req) begin
                    grant_en  = 1'b1;
                    grant_sel = ~cur_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_en) begin
            state_d = ACCESS;
            addr_d  = grant_sel ? m1_addr  : m0_addr;
            wdata_d = grant_sel ? m1_wdata : m0_wdata;
            we_d    = grant_sel ? m1_we    : m0_we;
            cur_d   = grant_sel;
            last_d  = grant_sel;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together at the edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            cur_q    <= 1'b0;
            last_q   <= 1'b1;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_din  = wdata_q;
    assign mem_we   = (state_q == ACCESS) &&  we_q && !oor;
    assign mem_re   = (state_q == ACCESS) && !we_q && !oor;

    assign m0_ack   = (state_q == RESP) && !cur_q;
    assign m1_ack   = (state_q == RESP) &&  cur_q;
    assign m0_err   = m0_ack && oor;
    assign m1_err   = m1_ack && oor;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 256-word negedge memory model.
// Covers MEM_ARB_RANGE_CHECK_EN in both configurations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout = '0;
    logic        mem_we, mem_re;

    logic [31:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
        .mem_dout(mem_dout)
    );

    // Memory model: write and read both land at the negedge inside ACCESS.
    always @(negedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_din;
        if (mem_re) mem_dout <= mem[mem_addr[7:0]];
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Starts from posedge+1; spends one cycle so the DUT is back in IDLE first.
    task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat,
                          output logic [31:0] rd, output bit er,
                          output bit saw_we, output bit saw_re, output bit dual);
        lat = 99; rd = '0; er = 1'b0; saw_we = 1'b0; saw_re = 1'b0; dual = 1'b0;
        @(posedge clk);
        #1;
        if (port) begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end else begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (mem_we) saw_we = 1'b1;
            if (mem_re) saw_re = 1'b1;
            if (m0_ack && m1_ack) dual = 1'b1;
            if (port ? m1_ack : m0_ack) begin
                lat = c;
                rd  = port ? m1_rdata : m0_rdata;
                er  = port ? m1_err : m0_err;
                break;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        bit          er, swe, sre, dual, late_ack;

        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
        mem[18] = 32'd99;

        vecs[0] = '{0, 0, 32'd18,  32'h0,        32'd99};
        vecs[1] = '{1, 1, 32'd5,   32'hDEADBEEF, 32'd0};
        vecs[2] = '{1, 0, 32'd5,   32'h0,        32'hDEADBEEF};
        vecs[3] = '{0, 1, 32'd18,  32'h1234,     32'd99};
        vecs[4] = '{0, 0, 32'd18,  32'h0,        32'h1234};
        vecs[5] = '{1, 0, 32'd200, 32'h0,        32'd200};
        vecs[6] = '{0, 0, 32'd255, 32'h0,        32'd255};
        vecs[7] = '{1, 1, 32'd255, 32'hA5A5,     32'd200};
        vecs[8] = '{0, 0, 32'd255, 32'h0,        32'hA5A5};

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack",   {m0_ack, m1_ack}, 0);
        check("rst_err",   {m0_err, m1_err}, 0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 0);
        check("rst_strb",  {mem_we, mem_re}, 0);
        check("rst_addr",  mem_addr, 0);
        check("rst_din",   mem_din, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-requester transactions
        foreach (vecs[i]) begin
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd, er, swe, sre, dual);
            check($sformatf("v%0d_lat", i), lat, 2);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), er, 0);
            check($sformatf("v%0d_strb", i), {swe, sre}, {vecs[i].we, ~vecs[i].we});
            check($sformatf("v%0d_dual", i), dual, 0);
        end

        // Simultaneous requests held: m0 wins first after reset, then alternate
        apply_reset();
        m0_we = 1'b0; m0_addr = 32'd10; m0_req = 1'b1;
        m1_we = 1'b0; m1_addr = 32'd20; m1_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rr_c%0d", c), {m0_ack, m1_ack},
                  {(c == 2 || c == 6), (c == 4 || c == 8)});
            if (c == 8) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
        end
        check("rr_m0_rdata", m0_rdata, 32'd10);
        check("rr_m1_rdata", m1_rdata, 32'd20);

        // m0 back-to-back reads with m1 idle: one ack every 3 cycles
        @(posedge clk);
        #1;
        m0_we = 1'b0; m0_addr = 32'd18; m0_req = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b_c%0d", c), {m0_ack, m1_ack}, {(c % 3 == 2), 1'b0});
            if (c == 11) m0_req = 1'b0;
        end
        check("b2b_rdata", m0_rdata, 32'h1234);

        // last is now 0, so m1 must win the next tie
        @(posedge clk);
        #1;
        m0_addr = 32'd1; m0_req = 1'b1;
        m1_we = 1'b0; m1_addr = 32'd2; m1_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("tie_after_b2b", {m0_ack, m1_ack}, 2'b01);
        m0_req = 1'b0;
        m1_req = 1'b0;

        // Reset during ACCESS of a write aborts it without ack
        @(posedge clk);
        #1;
        m1_we = 1'b1; m1_addr = 32'd7; m1_wdata = 32'hFFFF_FFFF; m1_req = 1'b1;
        @(posedge clk);
        #1;
        check("abort_we_before", mem_we, 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_we_dropped", mem_we, 0);
        m1_req = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ack_in_rst", {m0_ack, m1_ack}, 0);
        @(negedge clk);
        rst = 1'b0;
        late_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (m0_ack || m1_ack) late_ack = 1'b1;
        end
        check("abort_no_late_ack", late_ack, 0);
        check("abort_m1_rdata", m1_rdata, 0);
        do_txn(0, 0, 32'd7, 32'h0, lat, rd, er, swe, sre, dual);
        check("abort_readback", rd, 32'd7);

`ifdef MEM_ARB_RANGE_CHECK_EN
        do_txn(0, 1, 32'd300, 32'hCAFE, lat, rd, er, swe, sre, dual);
        check("oor_wr_lat", lat, 2);
        check("oor_wr_strb", {swe, sre}, 0);
        check("oor_wr_err", er, 1);
        check("oor_wr_rdata", rd, 32'd7);
        check("oor_mem_intact", mem[44], 32'd44);
        do_txn(0, 0, 32'd300, 32'h0, lat, rd, er, swe, sre, dual);
        check("oor_rd_lat", lat, 2);
        check("oor_rd_strb", {swe, sre}, 0);
        check("oor_rd_err", er, 1);
        check("oor_rd_rdata", rd, 0);
`else
        do_txn(0, 0, 32'd300, 32'h0, lat, rd, er, swe, sre, dual);
        check("nochk_rd_lat", lat, 2);
        check("nochk_rd_re", sre, 1);
        check("nochk_rd_err", er, 0);
        check("nochk_rd_rdata", rd, 32'd44);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
